// File: rtl/amcp_txq_pkg.sv
// rtl/amcp_txq_pkg.sv - shared types, defaults and pointer-width helper for the transmit queue
//
// Purpose : payload type shared with the multi-cycle-path CDC block, default
//           sizing, and the pointer width (index bits plus one wrap bit).
// Ports   : none (package).

package amcp_txq_pkg;

    // Must match the data type of the CDC sender downstream.
    typedef logic [7:0] dat_t;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/amcp_txq_if.sv
// rtl/amcp_txq_if.sv - producer, flush, CDC-sender and status signals of the transmit queue
//
// Purpose : bundles every non-clock signal of amcp_txq.
// Modports: slave  - the queue itself (amcp_txq)
//           master - whatever drives the queue (producer + CDC sender side)
// Signals : in_valid/in_ready/in_data  producer handshake
//           aflush                     synchronous clear
//           asend/aready/adatain       hand-off to the CDC sender
//           acount/aempty/afull        fill level
//           asent_cnt                  words handed off since reset (wraps)

interface amcp_txq_if #(
    parameter int DEPTH = amcp_txq_pkg::DEF_DEPTH,
    parameter int CNT_W = amcp_txq_pkg::DEF_CNT_W
);
    import amcp_txq_pkg::*;

    localparam int PW = ptr_w(DEPTH);

    logic             in_valid;
    logic             in_ready;
    dat_t             in_data;
    logic             aflush;
    dat_t             adatain;
    logic             asend;
    logic             aready;
    logic [PW-1:0]    acount;
    logic             aempty;
    logic             afull;
    logic [CNT_W-1:0] asent_cnt;

    modport slave (
        input  in_valid, in_data, aflush, aready,
        output in_ready, adatain, asend, acount, aempty, afull, asent_cnt
    );

    modport master (
        output in_valid, in_data, aflush, aready,
        input  in_ready, adatain, asend, acount, aempty, afull, asent_cnt
    );

endinterface

// File: rtl/amcp_txq_fifo.sv
// rtl/amcp_txq_fifo.sv - storage, wrap-bit pointers and fill level for the transmit queue
//
// Purpose : DEPTH-entry FIFO with no bypass; read data comes straight from
//           storage at the read pointer.
// Ports   : clk_i, rst_ni      clock, asynchronous active-low reset
//           push_i, wdata_i    write wdata_i at the write pointer
//           pop_i              advance the read pointer
//           flush_i            both pointers to zero on the next edge
//           rdata_o            head-of-queue word
//           count_o, empty_o, full_o  fill level

module amcp_txq_fifo
    import amcp_txq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int PW   = ptr_w(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  dat_t          wdata_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output dat_t          rdata_o,
    output logic [PW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int AW = PW - 1;

    dat_t          mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Self-protecting against overflow/underflow; flush wins over both.
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + PW'(1);
            if (pop_ok)  rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is deliberately not reset; the head is don't-care while empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/amcp_txq.sv
// rtl/amcp_txq.sv - transmit queue in front of the multi-cycle-path CDC sender
//
// Purpose : buffers producer words and hands them one at a time to the CDC
//           sender, hiding the sender's ready/acknowledge round trip.
// Ports   : aclk    sole clock
//           arst_n  asynchronous active-low reset
//           bus     amcp_txq_if.slave (producer, flush, sender, status)

module amcp_txq
    import amcp_txq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic       aclk,
    input  logic       arst_n,
    amcp_txq_if.slave  bus
);

    localparam int PW = ptr_w(DEPTH);

    logic             in_ready_w;
    logic             asend_w;
    logic             push;
    logic             empty;
    logic             full;
    logic [PW-1:0]    count;
    dat_t             head;
    logic [CNT_W-1:0] asent_cnt_q, asent_cnt_d;

    // Both handshakes depend only on registered state plus aready/aflush,
    // never on in_valid. asend lasts one edge per word because the sender
    // drops aready the cycle after it sees asend.
    assign in_ready_w = !full && !bus.aflush;
    assign asend_w    = bus.aready && !empty && !bus.aflush;
    assign push       = bus.in_valid && in_ready_w;

    amcp_txq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (aclk),
        .rst_ni  (arst_n),
        .push_i  (push),
        .wdata_i (bus.in_data),
        .pop_i   (asend_w),
        .flush_i (bus.aflush),
        .rdata_o (head),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    always_comb begin
        asent_cnt_d = asent_cnt_q;
        if (asend_w) asent_cnt_d = asent_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) asent_cnt_q <= '0;
        else         asent_cnt_q <= asent_cnt_d;
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.asend     = asend_w;
    assign bus.adatain   = head;
    assign bus.acount    = count;
    assign bus.aempty    = empty;
    assign bus.afull     = full;
    assign bus.asent_cnt = asent_cnt_q;

endmodule

// File: tb/tb_amcp_txq.sv
// tb/tb_amcp_txq.sv - directed self-checking bench for amcp_txq

module tb_amcp_txq;
    import amcp_txq_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic aclk;
    logic arst_n;

    amcp_txq_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    amcp_txq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .aclk   (aclk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int   n_chk  = 0;
    int   n_fail = 0;

    dat_t prod_q[$];
    dat_t rx[$];
    logic snd_en;
    int   busy_cyc;
    int   busy;
    logic s_sent;
    logic s_acc;
    dat_t s_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.in_valid = (prod_q.size() > 0);
        bus.in_data  = (prod_q.size() > 0) ? prod_q[0] : 8'h00;
        bus.aready   = snd_en && (busy == 0);
    endtask

    task automatic at_neg();
        @(negedge aclk);
        s_sent = bus.asend;
        s_data = bus.adatain;
        s_acc  = bus.in_valid && bus.in_ready;
    endtask

    task automatic at_pos();
        @(posedge aclk);
        #1;
        if (s_acc) void'(prod_q.pop_front());
        if (s_sent) begin
            rx.push_back(s_data);
            busy = busy_cyc;
        end else if (busy > 0) begin
            busy--;
        end
        drive();
    endtask

    task automatic tick();
        at_neg();
        at_pos();
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (rx.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, rx.size(), n);
    endtask

    initial begin
        arst_n      = 1'b0;
        bus.aflush  = 1'b0;
        snd_en      = 1'b1;
        busy_cyc    = 1;
        busy        = 0;
        s_sent      = 1'b0;
        s_acc       = 1'b0;
        s_data      = 8'h00;
        drive();
        repeat (2) @(posedge aclk);
        #1 arst_n = 1'b1;

        // reset / idle with aready high
        at_neg();
        chk("rst_asend", bus.asend, 0);
        chk("rst_aempty", bus.aempty, 1);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_acount", bus.acount, 0);
        chk("rst_afull", bus.afull, 0);
        chk("rst_asent_cnt", bus.asent_cnt, 0);
        at_pos();

        // three words queued while sender not ready, then drained in order
        snd_en = 1'b0;
        prod_q = '{8'h11, 8'h22, 8'h33};
        drive();
        repeat (3) tick();
        at_neg();
        chk("t3_acount", bus.acount, 3);
        chk("t3_asend", bus.asend, 0);
        at_pos();
        rx.delete();
        snd_en = 1'b1;
        drive();
        wait_rx("t3_rx_count", 3, 20);
        chk("t3_rx0", rx[0], 8'h11);
        chk("t3_rx1", rx[1], 8'h22);
        chk("t3_rx2", rx[2], 8'h33);
        at_neg();
        chk("t3_asent_cnt", bus.asent_cnt, 3);
        chk("t3_aempty", bus.aempty, 1);
        at_pos();

        // overfill: 5th word is held until the first pop
        snd_en = 1'b0;
        prod_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        drive();
        repeat (4) tick();
        at_neg();
        chk("full_afull", bus.afull, 1);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_acount", bus.acount, 4);
        at_pos();
        tick();
        chk("full_held", prod_q.size(), 1);
        rx.delete();
        snd_en = 1'b1;
        drive();
        wait_rx("full_rx_count", 5, 40);
        for (int i = 0; i < 5; i++) chk($sformatf("full_rx%0d", i), rx[i], 8'hA0 + i);
        at_neg();
        chk("full_asent_cnt", bus.asent_cnt, 8);
        chk("full_aempty", bus.aempty, 1);
        at_pos();

        // simultaneous push/pop at acount = 2 across pointer wrap
        snd_en   = 1'b0;
        busy_cyc = 0;
        prod_q   = '{8'h40, 8'h41};
        drive();
        repeat (2) tick();
        for (int i = 2; i < 14; i++) prod_q.push_back(8'h40 + i);
        rx.delete();
        snd_en = 1'b1;
        drive();
        for (int i = 0; i < 12; i++) begin
            at_neg();
            chk($sformatf("pp_acount%0d", i), bus.acount, 2);
            at_pos();
        end
        wait_rx("pp_rx_count", 14, 20);
        for (int i = 0; i < 14; i++) chk($sformatf("pp_rx%0d", i), rx[i], 8'h40 + i);
        at_neg();
        chk("pp_asent_cnt", bus.asent_cnt, 22);
        at_pos();
        busy_cyc = 1;

        // flush with three queued words and sender ready
        snd_en = 1'b0;
        prod_q = '{8'h91, 8'h92, 8'h93};
        drive();
        repeat (3) tick();
        rx.delete();
        snd_en     = 1'b1;
        bus.aflush = 1'b1;
        prod_q.push_back(8'h99);
        drive();
        at_neg();
        chk("fl_asend", bus.asend, 0);
        chk("fl_in_ready", bus.in_ready, 0);
        chk("fl_acount_pre", bus.acount, 3);
        at_pos();
        at_neg();
        chk("fl_acount", bus.acount, 0);
        chk("fl_aempty", bus.aempty, 1);
        chk("fl_held_asend", bus.asend, 0);
        chk("fl_asent_cnt", bus.asent_cnt, 22);
        at_pos();
        prod_q.delete();
        bus.aflush = 1'b0;
        drive();
        at_neg();
        chk("fl_after_acount", bus.acount, 0);
        at_pos();
        chk("fl_rx_none", rx.size(), 0);

        // counter wrap with the data stream intact (22 + 234 = 256)
        rx.delete();
        for (int i = 0; i < 234; i++) prod_q.push_back(dat_t'(i));
        drive();
        wait_rx("wr_rx_233", 233, 1000);
        at_neg();
        chk("wr_cnt_max", bus.asent_cnt, 8'hFF);
        at_pos();
        wait_rx("wr_rx_count", 234, 20);
        for (int i = 0; i < 234; i++) chk($sformatf("wr_rx%0d", i), rx[i], i & 8'hFF);
        at_neg();
        chk("wr_cnt_zero", bus.asent_cnt, 0);
        at_pos();
        prod_q = '{8'h5A, 8'h5B, 8'h5C};
        drive();
        wait_rx("wr_post_count", 237, 40);
        chk("wr_post_rx", rx[236], 8'h5C);
        at_neg();
        chk("wr_cnt_post", bus.asent_cnt, 3);
        at_pos();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/amcp_txq.md
# amcp_txq

Source-side transmit queue in the aclk domain, sitting directly upstream of the multi-cycle-path CDC block. Accepts words from a valid/ready producer at up to one per cycle, buffers them in a small FIFO, and hands them one at a time to the CDC sender through its aready/asend/adatain handshake. This hides the multi-cycle round-trip of the ready/acknowledge loop from the producer.

## Interface
- dat_t, logic [7:0], payload type; must match the CDC block's data type
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- CNT_W, 16, width of the handed-off word counter
- aclk  in  1  sole clock
- arst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  producer word valid
- in_ready  out  1  queue can accept; equals !afull && !aflush
- in_data  in  dat_t  producer word
- aflush  in  1  synchronous clear of queued words
- adatain  out  dat_t  head-of-queue word to the CDC sender
- asend  out  1  hand-off request; equals aready && !aempty && !aflush
- aready  in  1  CDC sender ready (registered in sender)
- acount  out  $clog2(DEPTH)+1  words currently queued
- aempty  out  1  acount == 0
- afull  out  1  acount == DEPTH
- asent_cnt  out  CNT_W  words handed off since reset; wraps

## Operation
- Push: in_valid && in_ready at a rising aclk edge writes in_data at the write pointer and advances it.
- Pop: asend at a rising aclk edge advances the read pointer and increments asent_cnt. The sender captures adatain on the same edge.
- Pointers are log2(DEPTH)+1 bits with a wrap bit. Empty: pointers are equal. Full: the low bits are equal and the wrap bits differ. acount = wptr − rptr (modulo).
- Push and pop in the same cycle: both happen and acount is unchanged. This is legal at any fill level except empty, where no pop occurs, and full, where no push occurs. No bypass path exists.
- adatain is driven combinationally from storage at the read pointer. Its value is don't-care when aempty, but it must be stable while asend is high.
- aflush: asend and in_ready are forced low that cycle. On the next edge both pointers reset to 0 and acount goes to 0. asent_cnt is unaffected.
  - A word already accepted by the sender, and the sender's BUSY state, are unaffected.
  - If aflush is held, the queue stays empty.
- asent_cnt wraps from 2^CNT_W−1 to 0 without any flag.

## Timing
- Reset values: in_ready = 1, asend = 0, acount = 0, aempty = 1, afull = 0, asent_cnt = 0. adatain is driven by storage, whose contents are not reset, so adatain is don't-care until the first push.
- Latency: a word pushed at edge N is at the head, with asend possible, in cycle N+1.
- Throughput to the sender: one word per sender ready cycle. aready drops the cycle after asend, so the queue must never hold asend high across two edges for one word.
- in_ready and asend are combinational from registered state plus aready/aflush. There is no combinational path from in_valid to any output.
- Reset mid-operation asynchronously empties the queue. Words in flight in the CDC block are the sender's concern.

## Structure
- Shared package: dat_t default, plus a function computing pointer width from DEPTH.
- Sub-module amcp_txq_fifo: storage array, pointers, acount/aempty/afull, push/pop/flush inputs.
- Top level: handshake gating (in_ready, asend) and the asent_cnt counter.

## Test plan
- Reset, then idle with aready = 1: asend = 0, aempty = 1, in_ready = 1, acount = 0, asent_cnt = 0.
- Push 0x11, 0x22, 0x33 back-to-back with aready = 0: acount = 3, asend = 0. Raise aready pulsed by the sender model: adatain is 0x11, then 0x22, then 0x33, one per asend edge; asent_cnt = 3; aempty = 1.
- With DEPTH = 4 and aready = 0, push 5 words: afull = 1 and in_ready = 0 after the 4th. The 5th is held by the producer and accepted on the first pop. FIFO order is preserved (0xA0–0xA4).
- Simultaneous push and pop at acount = 2: acount stays 2, and the popped and pushed values are correct across pointer wrap (run 3×DEPTH words).
- Assert aflush with acount = 3 while aready = 1: asend = 0 that cycle, acount = 0 next cycle, asent_cnt unchanged. A push attempted during aflush is not accepted.
- Preload asent_cnt near 0xFFFF by sending 65 536 words through the full loop with the mcp sender/receiver: asent_cnt wraps to 0 and the received data sequence is intact.
